clk_select_ctrl: RTL and testbench



---
 rtl/clk_select_ctrl_pkg.sv | 20 ++
 rtl/clk_select_ctrl_edge_counter.sv | 72 +++++++
 rtl/clk_select_ctrl.sv | 138 +++++++++++++
 tb/tb_clk_select_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_select_ctrl_pkg.sv
// Shared clocking constants for the clock-selection controller and the clock-mux wrappers:
// the mux-select state encoding and the edge-counter width.
package clk_select_ctrl_pkg;

    // Width of the per-clock edge counters; counts saturate at all-ones.
    localparam int unsigned EdgeCntW = 16;
    localparam logic [EdgeCntW-1:0] EdgeCntMax = '1;

    // Mux-select state; the encoding doubles as the mux select bit (1 = clock 1).
    typedef enum logic {
        Sel0 = 1'b0,
        Sel1 = 1'b1
    } sel_state_e;

    // Map a select bit onto the state encoding.
    function automatic sel_state_e sel_from_bit(input logic b);
        return b ? Sel1 : Sel0;
    endfunction

endpackage

// File: rtl/clk_select_ctrl_edge_counter.sv
// Per-candidate-clock activity monitor: synchronizes the divided toggle, counts toggle edges
// over one measurement window and flags the clock valid when the count lies in range.
module clk_edge_counter
    import clk_select_ctrl_pkg::*;
#(
    parameter int unsigned MinEdges = 200,
    parameter int unsigned MaxEdges = 300
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic toggle_i,
    input  logic win_end_i,
    output logic valid_o
);

    localparam logic [EdgeCntW-1:0] MinCnt = EdgeCntW'(MinEdges);
    localparam logic [EdgeCntW-1:0] MaxCnt = EdgeCntW'(MaxEdges);

    logic                sync1_q;
    logic                sync2_q;
    logic                hist_q;
    logic                edge_det;
    logic [EdgeCntW-1:0] cnt_q;
    logic [EdgeCntW-1:0] cnt_d;
    logic [EdgeCntW-1:0] cnt_inc;
    logic                valid_q;
    logic                valid_d;

    // Two-flop synchronizer for the asynchronous toggle plus one history flop for edge detect.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= toggle_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    // Either polarity of the divided toggle is one edge.
    assign edge_det = sync2_q ^ hist_q;

    // Saturating count; at window end the count including this cycle's edge is judged.
    always_comb begin
        cnt_inc = cnt_q;
        if (edge_det && (cnt_q != EdgeCntMax)) begin
            cnt_inc = cnt_q + 1'b1;
        end
        cnt_d   = cnt_inc;
        valid_d = valid_q;
        if (win_end_i) begin
            valid_d = (cnt_inc >= MinCnt) && (cnt_inc <= MaxCnt);
            cnt_d   = '0;
        end
    end

    // Edge count and window verdict registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign valid_o = valid_q;

endmodule

// File: rtl/clk_select_ctrl.sv
// Clock-selection controller: measures both candidate clocks per window, drives the
// glitch-free mux select, fails over on loss of the selected clock and reverts to the
// preferred clock after a hold-off of consecutive good windows.
module clk_select_ctrl
    import clk_select_ctrl_pkg::*;
#(
    parameter int unsigned WindowCycles_Gen   = 1000,
    parameter int unsigned MinEdges_Gen       = 200,
    parameter int unsigned MaxEdges_Gen       = 300,
    parameter int unsigned HoldoffWindows_Gen = 4
) (
    input  logic SysClk_ClkIn,
    input  logic SysRst_RstIn,
    input  logic Clk0Toggle_DatIn,
    input  logic Clk1Toggle_DatIn,
    input  logic PreferClk1_EnIn,
    input  logic ForceEn_EnIn,
    input  logic ForceClk1_EnIn,
    output logic SelecteClk1_EnOut,
    output logic Clk0Valid_DatOut,
    output logic Clk1Valid_DatOut,
    output logic SwitchEvt_EvtOut
);

    localparam int unsigned       WinW    = $clog2(WindowCycles_Gen);
    localparam logic [WinW-1:0]   WinLast = WinW'(WindowCycles_Gen - 1);
    localparam int unsigned       GoodW   = $clog2(HoldoffWindows_Gen + 1);
    localparam logic [GoodW-1:0]  GoodMax = GoodW'(HoldoffWindows_Gen);

    logic [WinW-1:0]  win_cnt_q;
    logic             win_end;
    logic             eval_q;
    logic             clk0_valid;
    logic             clk1_valid;

    sel_state_e       state_q;
    sel_state_e       state_d;
    sel_state_e       pref_sel;
    logic [GoodW-1:0] good_q;
    logic [GoodW-1:0] good_d;
    logic [GoodW-1:0] good_upd;
    logic             evt_q;
    logic             pref_q;
    logic             cur_valid;
    logic             oth_valid;
    logic             pref_valid;

    assign win_end = (win_cnt_q == WinLast);

    // Free-running window counter; eval_q marks the cycle after the valid flags update.
    always_ff @(posedge SysClk_ClkIn) begin
        if (SysRst_RstIn) begin
            win_cnt_q <= '0;
            eval_q    <= 1'b0;
        end else begin
            win_cnt_q <= win_end ? '0 : win_cnt_q + 1'b1;
            eval_q    <= win_end;
        end
    end

    clk_edge_counter #(
        .MinEdges (MinEdges_Gen),
        .MaxEdges (MaxEdges_Gen)
    ) u_clk0_mon (
        .clk_i     (SysClk_ClkIn),
        .rst_i     (SysRst_RstIn),
        .toggle_i  (Clk0Toggle_DatIn),
        .win_end_i (win_end),
        .valid_o   (clk0_valid)
    );

    clk_edge_counter #(
        .MinEdges (MinEdges_Gen),
        .MaxEdges (MaxEdges_Gen)
    ) u_clk1_mon (
        .clk_i     (SysClk_ClkIn),
        .rst_i     (SysRst_RstIn),
        .toggle_i  (Clk1Toggle_DatIn),
        .win_end_i (win_end),
        .valid_o   (clk1_valid)
    );

    // Selection decision: force wins every cycle; otherwise failover, then hold-off revert.
    always_comb begin
        pref_sel   = sel_from_bit(PreferClk1_EnIn);
        cur_valid  = (state_q == Sel1) ? clk1_valid : clk0_valid;
        oth_valid  = (state_q == Sel1) ? clk0_valid : clk1_valid;
        pref_valid = PreferClk1_EnIn ? clk1_valid : clk0_valid;

        // The revert test sees the count including the window just judged.
        good_upd = good_q;
        if (eval_q) begin
            if (!pref_valid) begin
                good_upd = '0;
            end else if (good_q != GoodMax) begin
                good_upd = good_q + 1'b1;
            end
        end

        state_d = state_q;
        if (ForceEn_EnIn) begin
            state_d = sel_from_bit(ForceClk1_EnIn);
        end else if (eval_q) begin
            if (!cur_valid && oth_valid) begin
                state_d = (state_q == Sel1) ? Sel0 : Sel1;
            end else if (cur_valid && (state_q != pref_sel) && (good_upd == GoodMax)) begin
                state_d = pref_sel;
            end
        end

        // Any switch or change of preference restarts the hold-off.
        good_d = good_upd;
        if ((state_d != state_q) || (PreferClk1_EnIn != pref_q)) begin
            good_d = '0;
        end
    end

    // Selection FSM with registered select and switch pulse.
    always_ff @(posedge SysClk_ClkIn) begin
        if (SysRst_RstIn) begin
            state_q <= Sel0;
            good_q  <= '0;
            evt_q   <= 1'b0;
            pref_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            evt_q   <= (state_d != state_q);
            pref_q  <= PreferClk1_EnIn;
        end
    end

    assign SelecteClk1_EnOut = (state_q == Sel1);
    assign Clk0Valid_DatOut  = clk0_valid;
    assign Clk1Valid_DatOut  = clk1_valid;
    assign SwitchEvt_EvtOut  = evt_q;

endmodule

// File: tb/tb_clk_select_ctrl.sv
// Bench for clk_select_ctrl: per-window edge-count schedules drive both toggles, a reference
// model predicts switches and per-window flags into queues, a monitor pops and compares.
module tb_clk_select_ctrl;

    localparam int W    = 100;
    localparam int MinE = 20;
    localparam int MaxE = 30;
    localparam int Hold = 3;
    localparam int NWin = 32;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic t0   = 1'b0;
    logic t1   = 1'b0;
    logic pref = 1'b0;
    logic fen  = 1'b0;
    logic fclk = 1'b0;
    logic sel;
    logic v0;
    logic v1;
    logic evt;

    always #5 clk = ~clk;

    clk_select_ctrl #(
        .WindowCycles_Gen   (W),
        .MinEdges_Gen       (MinE),
        .MaxEdges_Gen       (MaxE),
        .HoldoffWindows_Gen (Hold)
    ) dut (
        .SysClk_ClkIn      (clk),
        .SysRst_RstIn      (rst),
        .Clk0Toggle_DatIn  (t0),
        .Clk1Toggle_DatIn  (t1),
        .PreferClk1_EnIn   (pref),
        .ForceEn_EnIn      (fen),
        .ForceClk1_EnIn    (fclk),
        .SelecteClk1_EnOut (sel),
        .Clk0Valid_DatOut  (v0),
        .Clk1Valid_DatOut  (v1),
        .SwitchEvt_EvtOut  (evt)
    );

    typedef struct {
        int   cyc;
        logic sel;
    } sw_rec_t;

    typedef struct {
        int   cyc;
        logic v0;
        logic v1;
        logic sel;
    } win_rec_t;

    sw_rec_t  sw_q[$];
    win_rec_t win_q[$];
    int n_vec  = 0;
    int n_fail = 0;
    int mcyc   = 0;

    // Per-window schedule: edges per window for each clock, preference, force window.
    int n0s[NWin];
    int n1s[NWin];
    bit prf[NWin];
    bit frc[NWin];
    bit fval[NWin];

    // Reference model state.
    int       cyc;
    logic [3:0] h0;
    logic [3:0] h1;
    int       c0;
    int       c1;
    bit       mv0;
    bit       mv1;
    bit       mst;
    int       good;
    bit       pref_prev;

    always @(posedge clk) mcyc <= rst ? 0 : mcyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, mcyc,
                     $time);
        end
    endtask

    // Does a clock with n edges per window change at window offset of counting cycle q?
    function automatic bit tog(input int n, input int q);
        int o;
        o = (q - 1) % W;
        return ((o + 1) * n / W) != (o * n / W);
    endfunction

    function automatic int pick();
        case ($urandom_range(0, 7))
            0: return 0;
            1: return 19;
            2: return 20;
            3: return 25;
            4: return 30;
            5: return 31;
            6: return 100;
            default: return int'($urandom_range(0, 60));
        endcase
    endfunction

    task automatic model_reset();
        cyc       = 0;
        h0        = '0;
        h1        = '0;
        c0        = 0;
        c1        = 0;
        mv0       = 1'b0;
        mv1       = 1'b0;
        mst       = 1'b0;
        good      = 0;
        pref_prev = 1'b0;
        sw_q.delete();
        win_q.delete();
    endtask

    // Drive inputs for the next sampling edge and advance the model by that edge.
    task automatic step();
        int w;
        int o;
        int q;
        bit ev;
        bit new_st;
        bit cur_ok;
        bit oth_ok;
        cyc++;
        w = (cyc - 1) / W;
        o = (cyc - 1) % W;
        // A change sampled now is counted two edges later, so follow that edge's window.
        q = cyc + 2;
        t0   = t0 ^ tog(n0s[(q - 1) / W], q);
        t1   = t1 ^ tog(n1s[(q - 1) / W], q);
        pref = (o >= 50 || w == 0) ? prf[w] : prf[w - 1];
        fen  = frc[w] && (o >= 30) && (o < 70);
        fclk = fval[w] ^ (o >= 50);

        h0 = {h0[2:0], t0};
        h1 = {h1[2:0], t1};
        ev = (cyc > W) && (o == 0);

        if (ev) begin
            if (pref ? mv1 : mv0) good = (good < Hold) ? good + 1 : Hold;
            else good = 0;
        end
        new_st = mst;
        if (fen) begin
            new_st = fclk;
        end else if (ev) begin
            cur_ok = mst ? mv1 : mv0;
            oth_ok = mst ? mv0 : mv1;
            if (!cur_ok && oth_ok) new_st = !mst;
            else if (cur_ok && (mst != pref) && (good == Hold)) new_st = pref;
        end
        if ((new_st != mst) || (pref != pref_prev)) good = 0;
        pref_prev = pref;
        if (new_st != mst) sw_q.push_back('{cyc, new_st});
        mst = new_st;
        if (ev) win_q.push_back('{cyc, mv0, mv1, mst});

        c0 += int'(h0[2] ^ h0[3]);
        c1 += int'(h1[2] ^ h1[3]);
        if (cyc % W == 0) begin
            mv0 = (c0 >= MinE) && (c0 <= MaxE);
            mv1 = (c1 >= MinE) && (c1 <= MaxE);
            c0  = 0;
            c1  = 0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_select"}, sel, 0);
        check({tag, "_clk0_valid"}, v0, 0);
        check({tag, "_clk1_valid"}, v1, 0);
        check({tag, "_switch_evt"}, evt, 0);
    endtask

    // Monitor: compares per-window flags at evaluation and every switch pulse.
    initial begin : monitor
        sw_rec_t  s;
        win_rec_t r;
        forever begin
            @(posedge clk);
            #2;
            while (sw_q.size() > 0 && sw_q[0].cyc < mcyc) begin
                s = sw_q.pop_front();
                check("switch_evt_missing_at_cycle", mcyc, s.cyc);
            end
            if (win_q.size() > 0 && win_q[0].cyc == mcyc) begin
                r = win_q.pop_front();
                check("clk0_valid", v0, r.v0);
                check("clk1_valid", v1, r.v1);
                check("window_select", sel, r.sel);
            end
            if (evt === 1'b1) begin
                if (sw_q.size() == 0) begin
                    check("switch_evt_unexpected", evt, 0);
                end else begin
                    s = sw_q.pop_front();
                    check("switch_cycle", mcyc, s.cyc);
                    check("switch_select", sel, s.sel);
                end
            end
        end
    end

    initial begin : driver
        // Directed opening: power-up revert, failover, interrupted revert, bounds, dead, force.
        int d0[15] = '{25, 25, 25, 25, 25, 25, 25, 25, 25, 25, 20, 19, 100, 0, 0};
        int d1[15] = '{25, 25, 25, 0, 25, 25, 0, 25, 25, 25, 30, 31, 25, 0, 0};
        for (int i = 0; i < NWin; i++) begin
            n0s[i]  = (i < 15) ? d0[i] : pick();
            n1s[i]  = (i < 15) ? d1[i] : pick();
            prf[i]  = (i < 15) ? 1'b1 : 1'(($urandom_range(0, 3)) == 0 ? 1 : 0) ^ 1'b1;
            frc[i]  = (i == 12) || (i >= 15 && $urandom_range(0, 3) == 0);
            fval[i] = (i == 12) ? 1'b0 : 1'($urandom_range(0, 1));
        end

        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("por");

        for (int i = 0; i < 25 * W + 57; i++) begin
            @(negedge clk);
            rst = 1'b0;
            step();
        end

        // Mid-window reset, then a second run preferring clock 0.
        @(negedge clk);
        rst = 1'b1;
        fen = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_outputs("midrst");

        for (int i = 0; i < NWin; i++) begin
            n0s[i]  = (i < 3) ? 25 : pick();
            n1s[i]  = (i < 3) ? 25 : pick();
            prf[i]  = (i < 4) ? 1'b0 : 1'($urandom_range(0, 1));
            frc[i]  = (i >= 4) && ($urandom_range(0, 3) == 0);
            fval[i] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 10 * W + 5; i++) begin
            rst = 1'b0;
            step();
            @(negedge clk);
        end

        @(posedge clk);
        #3;
        check("pending_switch_records", sw_q.size(), 0);
        check("pending_window_records", win_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
